calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_timeout.sv | 31 +++
 rtl/calc_ctrl.sv | 121 ++++++++++++
 tb/tb_calc_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcode, error-code and state definitions for the calc request controller.
package calc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_SQR = 3'b100;

  localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [ERR_W-1:0] ERR_DIV0    = 2'b10;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Opcodes above square are reserved and rejected at acceptance.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_SQR);
  endfunction

endpackage

// File: rtl/calc_timeout.sv
// WAIT-state watchdog: counts WAIT cycles and flags the cycle that is the TIMEOUT-th one.
module calc_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

  logic [CNT_W-1:0] count;

  // count holds completed WAIT cycles; expired is set one edge ahead so it is
  // high during the final allowed WAIT cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= (TIMEOUT <= 1);
    end else if (enable && !expired) begin
      count   <= count + CNT_W'(1);
      expired <= (32'(count) + 32'd2 >= TIMEOUT);
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Request controller: accepts an arithmetic request, drives the shared datapath,
// and reports a registered result with an error code.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W  = 27,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [OP_W-1:0]            arith,
  input  logic signed [DATA_W-1:0]   data1,
  input  logic signed [DATA_W-1:0]   data2,
  output logic [OP_W-1:0]            dp_op,
  output logic signed [DATA_W-1:0]   dp_a,
  output logic signed [DATA_W-1:0]   dp_b,
  output logic                       dp_start,
  input  logic                       dp_done,
  input  logic signed [2*DATA_W-1:0] dp_result,
  output logic signed [2*DATA_W-1:0] data3,
  output logic                       data_latch,
  output logic                       busy,
  output logic [ERR_W-1:0]           err
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam logic signed [RES_W-1:0] SAT_POS = {1'b0, {(RES_W-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SAT_NEG = {1'b1, {(RES_W-1){1'b0}}};

  state_t state;
  logic   req_legal;
  logic   req_div0;
  logic   tmo_clear;
  logic   tmo_enable;
  logic   tmo_expired;

  assign req_legal  = op_legal(arith);
  assign req_div0   = (arith == OP_DIV) && (data2 == '0);
  assign tmo_clear  = (state == ST_ISSUE);
  assign tmo_enable = (state == ST_WAIT);

  calc_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // dp_op/dp_a/dp_b double as the request capture registers and stay put until
  // the next acceptance, so they are stable from ISSUE through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dp_start   <= 1'b0;
      data_latch <= 1'b0;
      busy       <= 1'b0;
      data3      <= '0;
      err        <= ERR_OK;
      dp_op      <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
    end else begin
      dp_start   <= 1'b0;
      data_latch <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            dp_op <= arith;
            dp_a  <= data1;
            dp_b  <= data2;
            busy  <= 1'b1;
            if (!req_legal) begin
              state      <= ST_ERR;
              data_latch <= 1'b1;
              data3      <= '0;
              err        <= ERR_ILLEGAL;
            end else if (req_div0) begin
              state      <= ST_ERR;
              data_latch <= 1'b1;
              data3      <= data1[DATA_W-1] ? SAT_NEG : SAT_POS;
              err        <= ERR_DIV0;
            end else begin
              state    <= ST_ISSUE;
              dp_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        // A done in the final allowed cycle beats the timeout.
        ST_WAIT: begin
          if (dp_done) begin
            state      <= ST_LATCH;
            data_latch <= 1'b1;
            data3      <= dp_result;
            err        <= ERR_OK;
          end else if (tmo_expired) begin
            state      <= ST_ERR;
            data_latch <= 1'b1;
            data3      <= '0;
            err        <= ERR_TIMEOUT;
          end
        end
        ST_LATCH, ST_ERR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed corner cases plus randomized requests
// against a cycle-offset/result reference model.
`timescale 1ns/1ps
module tb_calc_ctrl;

  localparam int DW = 27;
  localparam int RW = 2 * DW;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [2:0]           arith;
  logic signed [DW-1:0] data1;
  logic signed [DW-1:0] data2;
  logic [2:0]           dp_op;
  logic signed [DW-1:0] dp_a;
  logic signed [DW-1:0] dp_b;
  logic                 dp_start;
  logic                 dp_done;
  logic signed [RW-1:0] dp_result;
  logic signed [RW-1:0] data3;
  logic                 data_latch;
  logic                 busy;
  logic [1:0]           err;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     dp_delay = 1;
  int     dp_left = 0;
  logic   force_done = 1'b0;
  longint last_d3 = 0;
  longint last_err = 0;

  calc_ctrl #(
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .arith      (arith),
    .data1      (data1),
    .data2      (data2),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_start   (dp_start),
    .dp_done    (dp_done),
    .dp_result  (dp_result),
    .data3      (data3),
    .data_latch (data_latch),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Plain arithmetic meaning of each opcode.
  function automatic longint ref_calc(input logic [2:0] op, input longint a, input longint b);
    longint r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a * b;
      3'd3:    r = (b == 0) ? 0 : a / b;
      3'd4:    r = a * a;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Datapath stand-in: done is seen dp_delay edges after the start edge; 0 = never.
  always @(posedge clk) begin
    if (dp_start) dp_left <= dp_delay;
    else if (dp_left > 0) dp_left <= dp_left - 1;
  end
  assign dp_done   = (dp_left == 1) || force_done;
  assign dp_result = RW'(ref_calc(dp_op, longint'(dp_a), longint'(dp_b)));

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/busy"},       longint'(busy), 0);
    check({tag, "/dp_start"},   longint'(dp_start), 0);
    check({tag, "/data_latch"}, longint'(data_latch), 0);
    check({tag, "/data3"},      longint'(data3), 0);
    check({tag, "/err"},        longint'(err), 0);
    check({tag, "/dp_op"},      longint'(dp_op), 0);
    check({tag, "/dp_a"},       longint'(dp_a), 0);
    check({tag, "/dp_b"},       longint'(dp_b), 0);
  endtask

  // One request from an idle controller; offsets are counted in edges after acceptance.
  task automatic run_req(input int op_i, input int a_i, input int b_i, input int d,
                         input bit noise, input string tag);
    logic [2:0]           op;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    longint               exp_d3;
    longint               exp_err;
    int                   exp_lat;
    int                   exp_starts;
    int                   starts;
    int                   lat;
    op = 3'(op_i);
    a  = DW'(a_i);
    b  = DW'(b_i);
    starts = 0;
    lat    = -1;
    if (op > 3'd4) begin
      exp_err = 1; exp_d3 = 0; exp_lat = 1; exp_starts = 0;
    end else if (op == 3'd3 && b == 0) begin
      exp_err = 2;
      exp_d3  = (a < 0) ? -(64'sd1 <<< (RW - 1)) : (64'sd1 <<< (RW - 1)) - 1;
      exp_lat = 1; exp_starts = 0;
    end else if (d == 0 || d > TO) begin
      exp_err = 3; exp_d3 = 0; exp_lat = TO + 2; exp_starts = 1;
    end else begin
      exp_err = 0; exp_d3 = ref_calc(op, longint'(a), longint'(b));
      exp_lat = d + 2; exp_starts = 1;
    end
    check({tag, "/hold_data3"}, longint'(data3), last_d3);
    check({tag, "/hold_err"},   longint'(err), last_err);
    dp_delay = d;
    en = 1'b1; arith = op; data1 = a; data2 = b;
    @(negedge clk);
    en = 1'b0;
    for (int c = 1; c <= TO + 10 && lat < 0; c++) begin
      check({tag, "/busy"}, longint'(busy), 1);
      if (dp_start === 1'b1) begin
        starts++;
        check({tag, "/start_cycle"}, c, 1);
        check({tag, "/dp_op"}, longint'(dp_op), longint'(op));
        check({tag, "/dp_a"},  longint'(dp_a), longint'(a));
        check({tag, "/dp_b"},  longint'(dp_b), longint'(b));
      end
      if (data_latch === 1'b1) begin
        lat = c;
        check({tag, "/data3"}, longint'(data3), exp_d3);
        check({tag, "/err"},   longint'(err), exp_err);
      end
      if (noise && c < exp_lat) begin
        en    = 1'($urandom_range(0, 1));
        arith = 3'($urandom_range(0, 7));
        data1 = DW'($urandom);
        data2 = DW'($urandom);
      end
      @(negedge clk);
    end
    en = 1'b0;
    check({tag, "/latch_cycle"}, lat, exp_lat);
    check({tag, "/starts"}, starts, exp_starts);
    check({tag, "/idle_busy"}, longint'(busy), 0);
    check({tag, "/idle_latch"}, longint'(data_latch), 0);
    last_d3  = exp_d3;
    last_err = exp_err;
  endtask

  initial begin
    int op;
    int a;
    int b;
    int d;
    rst = 1'b1; en = 1'b0; arith = '0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run_req(0, 5, -3, 1, 1'b0, "add");
    run_req(3, 100, 7, 20, 1'b1, "div_slow");
    run_req(3, -9, 0, 1, 1'b0, "div0_neg");
    run_req(3, 9, 0, 1, 1'b0, "div0_pos");
    run_req(3, 0, 0, 1, 1'b1, "div0_zero");
    run_req(6, 12, 3, 1, 1'b0, "illegal_110");
    run_req(5, 12, 3, 1, 1'b0, "illegal_101");
    run_req(7, -1, 1, 1, 1'b1, "illegal_111");
    run_req(2, -1234, 5678, 3, 1'b0, "mul");
    run_req(1, -50000000, 60000000, 2, 1'b0, "sub");
    run_req(4, -(1 <<< 26), 0, 2, 1'b0, "sqr_min");
    run_req(3, -100, 7, 4, 1'b0, "div_neg");
    run_req(0, 1, 1, 0, 1'b1, "timeout");
    run_req(0, 7, 8, TO, 1'b0, "done_at_limit");
    run_req(0, 7, 8, TO + 1, 1'b0, "done_too_late");

    // Reset while in WAIT, then a stray done the following cycle.
    dp_delay = 0;
    en = 1'b1; arith = 3'd0; data1 = DW'(3); data2 = DW'(4);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid/busy_before", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_done = 1'b1;
    check_reset("rst_mid");
    @(negedge clk);
    force_done = 1'b0;
    check("rst_mid/stray_latch", longint'(data_latch), 0);
    check("rst_mid/stray_busy", longint'(busy), 0);
    last_d3 = 0;
    last_err = 0;
    run_req(0, 40, 2, 1, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom);
      b  = int'($urandom);
      d  = int'($urandom_range(1, 6));
      if (op == 3 && $urandom_range(0, 3) == 0) b = 0;
      if ($urandom_range(0, 9) == 0) d = 0;
      run_req(op, a, b, d, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
